// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit: fetch program counter with a direct-mapped branch target buffer.
//
// Holds the fetch pc, predicts the next pc from a BTB indexed by the current
// pc, resolves control-flow outcomes from execute, and redirects fetch on
// traps, misaligned taken targets and mispredictions.
//
// Ports
//   clk             in   sole clock, all state changes on the rising edge
//   rst_n           in   synchronous active-low reset
//   stall           in   hold the fetch pc
//   ex_valid        in   execute resolves a control-flow instruction this cycle
//   ex_pc           in   pc of the resolving instruction
//   ex_is_jalr      in   resolving instruction is JALR
//   ex_is_br        in   resolving instruction is a conditional branch or JAL
//   ex_taken        in   actual outcome (JAL/JALR drive 1)
//   ex_rs1, ex_imm  in   rs1 value and sign-extended immediate
//   ex_pred_taken   in   prediction carried with the instruction
//   ex_pred_target  in   predicted target carried with the instruction
//   trap_valid      in   trap redirect request
//   trap_vector     in   trap redirect target
//   pc              out  current fetch pc (registered)
//   npc             out  next fetch pc (combinational)
//   pred_taken      out  BTB predicts taken for pc (combinational)
//   pred_target     out  BTB predicted target for pc (combinational)
//   flush           out  squash younger instructions (combinational)
//   misalign        out  taken target not 4-byte aligned (combinational)
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_jalr,
  input  logic            ex_is_br,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush,
  output logic            misalign
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]        r_pc;
  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];
  logic [1:0]             r_btb_ctr    [BTB_ENTRIES];

  assign pc = r_pc;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup. The arrays are read combinationally from registers, so
  // a lookup always sees the contents from before any same-cycle update.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  logic             w_fetch_hit;
  logic [XLEN-1:0]  w_pc_plus4;

  assign w_fetch_idx = r_pc[IDX_W+1:2];
  assign w_fetch_tag = r_pc[XLEN-1:IDX_W+2];
  assign w_fetch_hit = r_btb_valid[w_fetch_idx] &&
                       (r_btb_tag[w_fetch_idx] == w_fetch_tag);
  assign w_pc_plus4  = r_pc + XLEN'(4);

  // Counter values 2 and 3 both have the upper bit set.
  assign pred_taken  = w_fetch_hit && r_btb_ctr[w_fetch_idx][1];
  assign pred_target = w_fetch_hit ? r_btb_target[w_fetch_idx] : w_pc_plus4;

  // ---------------------------------------------------------------------------
  // Execute-side resolution
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_ex_target;
  logic            w_misalign;
  logic            w_mispredict_raw;
  logic            w_mispredict;

  assign w_jalr_sum = ex_rs1 + ex_imm;

  always_comb begin
    w_ex_target = ex_pc + XLEN'(4);
    if (ex_is_jalr) begin
      w_ex_target = {w_jalr_sum[XLEN-1:1], 1'b0};
    end else if (ex_taken) begin
      w_ex_target = ex_pc + ex_imm;
    end
  end

  assign w_misalign       = ex_valid && ex_taken && (w_ex_target[1:0] != 2'b00);
  assign w_mispredict_raw = ex_valid &&
                            ((ex_taken != ex_pred_taken) ||
                             (ex_taken && (w_ex_target != ex_pred_target)));
  // A misaligned target is reported as misalign only, never as a mispredict.
  assign w_mispredict     = w_mispredict_raw && !w_misalign;

  assign misalign = w_misalign;
  assign flush    = trap_valid || w_misalign || w_mispredict;

  // ---------------------------------------------------------------------------
  // Next pc selection. Redirects beat stall; stall beats prediction. While in
  // reset the output shows the reset vector so no input leaks through.
  // ---------------------------------------------------------------------------
  always_comb begin
    npc = w_pc_plus4;
    if (!rst_n) begin
      npc = RESET_VECTOR;
    end else if (trap_valid) begin
      npc = trap_vector;
    end else if (w_misalign) begin
      npc = ex_pc;
    end else if (w_mispredict) begin
      npc = w_ex_target;
    end else if (stall) begin
      npc = r_pc;
    end else if (pred_taken) begin
      npc = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= npc;
    end
  end

  // ---------------------------------------------------------------------------
  // BTB training. Runs regardless of stall and trap; suppressed for
  // misaligned targets and while in reset.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_en;
  logic             w_upd_hit;
  logic             w_alloc;
  logic             w_train;
  logic [1:0]       w_ctr_old;
  logic [1:0]       w_ctr_next;

  assign w_upd_idx = ex_pc[IDX_W+1:2];
  assign w_upd_tag = ex_pc[XLEN-1:IDX_W+2];
  assign w_upd_en  = rst_n && ex_valid && (ex_is_br || ex_is_jalr) && !w_misalign;
  assign w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
  assign w_alloc   = w_upd_en && !w_upd_hit && ex_taken;
  assign w_train   = w_upd_en && w_upd_hit;
  assign w_ctr_old = r_btb_ctr[w_upd_idx];

  // Saturating two-bit counter step.
  always_comb begin
    w_ctr_next = w_ctr_old;
    if (ex_taken) begin
      if (w_ctr_old != 2'd3) w_ctr_next = w_ctr_old + 2'd1;
    end else begin
      if (w_ctr_old != 2'd0) w_ctr_next = w_ctr_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
    end else if (w_alloc) begin
      r_btb_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_btb_tag[w_upd_idx]    <= w_upd_tag;
      r_btb_target[w_upd_idx] <= w_ex_target;
      r_btb_ctr[w_upd_idx]    <= 2'd2;
    end else if (w_train) begin
      r_btb_ctr[w_upd_idx] <= w_ctr_next;
      if (ex_taken) begin
        r_btb_target[w_upd_idx] <= w_ex_target;
      end
    end
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set address/data width (>=16).
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the pc value after reset (4-byte aligned).
REQ-003 Parameter BTB_ENTRIES, default 16, SHALL set the direct-mapped BTB depth (power of 2, 2..256).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 stall  in  1  hold pc and suppress fetch-side prediction update.
REQ-007 ex_valid  in  1  execute stage resolves a control-flow instruction this cycle.
REQ-008 ex_pc  in  XLEN  pc of the resolving instruction.
REQ-009 ex_is_jalr  in  1  resolving instruction is JALR.
REQ-010 ex_is_br  in  1  resolving instruction is conditional branch or JAL.
REQ-011 ex_taken  in  1  actual outcome (JAL/JALR drive 1).
REQ-012 ex_rs1 / ex_imm  in  XLEN each  rs1 data and sign-extended immediate.
REQ-013 ex_pred_taken / ex_pred_target  in  1 / XLEN  prediction carried with the instruction.
REQ-014 trap_valid / trap_vector  in  1 / XLEN  trap redirect request and target.
REQ-015 pc  out  XLEN  current fetch pc (registered).
REQ-016 npc  out  XLEN  next pc (combinational).
REQ-017 pred_taken / pred_target  out  1 / XLEN  BTB prediction for current pc (combinational).
REQ-018 flush  out  1  squash younger instructions (combinational).
REQ-019 misalign  out  1  taken target not 4-byte aligned (combinational).

Function
REQ-020 Resolved target SHALL be: JALR (ex_rs1+ex_imm) with bit0 cleared; taken branch/JAL ex_pc+ex_imm; not taken ex_pc+4; all modulo 2^XLEN.
REQ-021 Mispredict SHALL be ex_valid & (ex_taken!=ex_pred_taken | (ex_taken & target!=ex_pred_target)).
REQ-022 Misalign SHALL be ex_valid & ex_taken & target[1:0]!=0; it overrides mispredict.
REQ-023 npc priority SHALL be: trap_valid -> trap_vector; misalign -> ex_pc; mispredict -> resolved target; stall -> pc; pred_taken -> pred_target; else pc+4.
REQ-024 trap and redirects SHALL override stall; pc <= npc every non-reset cycle.
REQ-025 flush SHALL equal trap_valid | misalign | mispredict.
REQ-026 BTB index SHALL be pc[log2(BTB_ENTRIES)+1:2]; tag the remaining upper bits; each entry holds valid, tag, target, 2-bit saturating counter.
REQ-027 pred_taken SHALL be hit & counter>=2; pred_target the entry target; on miss pred_taken=0, pred_target=pc+4.
REQ-028 BTB update SHALL occur when ex_valid & (ex_is_br|ex_is_jalr) & !misalign, indexed by ex_pc, regardless of stall.
REQ-029 On update hit: counter +1 if taken (sat. 3), -1 if not (sat. 0); target rewritten if taken.
REQ-030 On update miss: taken allocates (valid=1, tag, target, counter=2), overwriting any entry; not-taken no change.
REQ-031 Lookup and update same index same cycle: lookup SHALL see pre-update contents.
REQ-032 trap_valid SHALL not block a concurrent BTB update.

Reset
REQ-033 rst_n=0 at a clock edge SHALL set pc=RESET_VECTOR and clear all BTB valid bits; counters/targets need not reset.
REQ-034 During reset, inputs SHALL be ignored; first post-reset pc=RESET_VECTOR, pred_taken=0, npc=RESET_VECTOR+4.
REQ-035 Reset asserted mid-redirect or mid-stall SHALL take priority over all other npc sources.

Verification
REQ-036 Reset then 3 free-running cycles -> pc 0x0,0x4,0x8, pred_taken 0.
REQ-037 Branch at 0x10, ex_taken=1, imm=0x20, ex_pred_taken=0 -> flush=1, next pc=0x30; BTB entry allocated, counter 2; next fetch of 0x10 gives pred_taken=1, pred_target=0x30.
REQ-038 JALR rs1=0x101, imm=0x4, pred correct (0x104... wrong align) -> target 0x104, misalign=0 (bit0 cleared) ; JALR rs1=0x102 imm=0 -> misalign=1, flush=1, next pc=ex_pc, BTB unchanged.
REQ-039 stall=1 with pc=0x40 for 3 cycles -> pc stays 0x40; mispredict during stall -> pc loads target next cycle.
REQ-040 trap_valid=1, trap_vector=0x200 with simultaneous mispredict -> next pc=0x200, flush=1, BTB still updated.
REQ-041 Same branch not-taken twice from counter 2 -> counter 0, pred_taken=0; two BTB_ENTRIES-aliased pcs -> later allocation evicts earlier (tag mismatch, miss).
